// File: rtl/plic_target_arb.sv
// Per-target PLIC core: pending bits, priority/threshold arbitration, claim and complete.
// Optional macro PLIC_TARGET_ACTIVE_EN tracks claimed-not-completed IDs and filters completes with them.
module plic_target_arb #(
   parameter int IRQ_NUM    = 32,
   parameter int PRIO_WIDTH = 3,
   parameter int ID_WIDTH   = $clog2(IRQ_NUM)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [IRQ_NUM-1:0]            gw_valid_i,
   output logic [IRQ_NUM-1:0]            gw_ready_o,
   output logic [IRQ_NUM-1:0]            gw_comp_o,
   input  logic [IRQ_NUM*PRIO_WIDTH-1:0] prio_i,
   input  logic [IRQ_NUM-1:0]            ie_i,
   input  logic [PRIO_WIDTH-1:0]         thold_i,
   output logic [IRQ_NUM-1:0]            ip_o,
   input  logic                          claim_i,
   output logic [ID_WIDTH-1:0]           claim_id_o,
   input  logic                          comp_i,
   input  logic [ID_WIDTH-1:0]           comp_id_i,
   output logic [IRQ_NUM-1:0]            active_o,
   output logic                          irq_o
);

   logic [IRQ_NUM-1:0]    ip_q, ip_d;
   logic [IRQ_NUM-1:0]    claim_clr, cand, comp_gate;
   logic [IRQ_NUM-1:0]    gw_comp_q, gw_comp_d;
   logic [ID_WIDTH-1:0]   best_id_q, best_id_d;
   logic [PRIO_WIDTH-1:0] best_prio_q, best_prio_d;
   logic [PRIO_WIDTH-1:0] sel_prio;

   assign gw_ready_o = {~ip_q[IRQ_NUM-1:1], 1'b0};
   assign ip_o       = ip_q;
   assign claim_id_o = best_id_q;
   assign gw_comp_o  = gw_comp_q;
   // A qualifying winner always has prio > thold >= 0, so a nonzero prio means an irq.
   assign irq_o      = (best_prio_q != '0);

   always_comb begin
      claim_clr = '0;
      for (int k = 1; k < IRQ_NUM; k++)
         if (claim_i && best_id_q != '0 && ID_WIDTH'(k) == best_id_q) claim_clr[k] = 1'b1;
      ip_d    = (ip_q | (gw_valid_i & gw_ready_o)) & ~claim_clr;
      ip_d[0] = 1'b0;
   end

   // Arbitrate on held pending bits minus this cycle's claim: new requests show up one
   // cycle later (two-cycle request->irq), while a claimed ID is never offered again.
   always_comb begin
      cand      = ip_q & ~claim_clr & ie_i;
      best_id_d = '0;
      sel_prio  = thold_i;
      for (int k = 0; k < IRQ_NUM; k++)
         if (cand[k] && prio_i[k*PRIO_WIDTH +: PRIO_WIDTH] > sel_prio) begin
            best_id_d = ID_WIDTH'(k);
            sel_prio  = prio_i[k*PRIO_WIDTH +: PRIO_WIDTH];
         end
      best_prio_d = (best_id_d != '0) ? sel_prio : '0;
   end

   always_comb begin
      gw_comp_d = '0;
      for (int k = 0; k < IRQ_NUM; k++)
         if (comp_i && comp_id_i != '0 && ID_WIDTH'(k) == comp_id_i && ie_i[k] && comp_gate[k])
            gw_comp_d[k] = 1'b1;
   end

`ifdef PLIC_TARGET_ACTIVE_EN
   logic [IRQ_NUM-1:0] active_q, active_d;

   // Completes check the pre-claim active bit, so a same-cycle claim+complete is dropped.
   assign comp_gate = active_q;
   assign active_d  = (active_q & ~gw_comp_d) | claim_clr;
   assign active_o  = active_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) active_q <= '0;
      else       active_q <= active_d;
   end
`else
   assign comp_gate = '1;
   assign active_o  = '0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ip_q        <= '0;
         best_id_q   <= '0;
         best_prio_q <= '0;
         gw_comp_q   <= '0;
      end else begin
         ip_q        <= ip_d;
         best_id_q   <= best_id_d;
         best_prio_q <= best_prio_d;
         gw_comp_q   <= gw_comp_d;
      end
   end

endmodule

// File: tb/tb_plic_target_arb.sv
// Directed bench for plic_target_arb with 6 sources (IDs 6/7 exercise out-of-range completes).
module tb_plic_target_arb;
   localparam int N  = 6;
   localparam int PW = 3;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  gw_valid, gw_ready, gw_comp, ie, ip, active;
   logic [N*PW-1:0] prio;
   logic [PW-1:0] thold;
   logic          claim, comp, irq;
   logic [IW-1:0] claim_id, comp_id;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   plic_target_arb #(.IRQ_NUM(N), .PRIO_WIDTH(PW)) dut (
      .clk_i(clk), .rst_i(rst), .gw_valid_i(gw_valid), .gw_ready_o(gw_ready),
      .gw_comp_o(gw_comp), .prio_i(prio), .ie_i(ie), .thold_i(thold), .ip_o(ip),
      .claim_i(claim), .claim_id_o(claim_id), .comp_i(comp), .comp_id_i(comp_id),
      .active_o(active), .irq_o(irq)
   );

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_prio(input int id, input int p);
      prio[id*PW +: PW] = PW'(p);
   endtask

   task automatic test_reset();
      rst = 1; tick(); tick(); rst = 0;
      checks++; if (ip !== 6'b000000) begin errors++; $display("FAIL reset_ip got %b exp 000000", ip); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
      checks++; if (claim_id !== 3'd0) begin errors++; $display("FAIL reset_claim_id got %0d exp 0", claim_id); end
      checks++; if (gw_comp !== 6'b000000) begin errors++; $display("FAIL reset_gw_comp got %b exp 000000", gw_comp); end
      checks++; if (active !== 6'b000000) begin errors++; $display("FAIL reset_active got %b exp 000000", active); end
      checks++; if (gw_ready !== 6'b111110) begin errors++; $display("FAIL reset_gw_ready got %b exp 111110", gw_ready); end
   endtask

   task automatic test_pending_select();
      set_prio(1, 3); set_prio(2, 5); ie = 6'b000110; thold = 0;
      gw_valid = 6'b000110; tick(); gw_valid = '0;
      checks++; if (ip !== 6'b000110) begin errors++; $display("FAIL sel_ip got %b exp 000110", ip); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL sel_irq_early got %b exp 0", irq); end
      checks++; if (gw_ready !== 6'b111000) begin errors++; $display("FAIL sel_gw_ready got %b exp 111000", gw_ready); end
      tick();
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL sel_irq got %b exp 1", irq); end
      checks++; if (claim_id !== 3'd2) begin errors++; $display("FAIL sel_claim_id got %0d exp 2", claim_id); end
   endtask

   task automatic test_back_to_back();
      claim = 1; tick();
      checks++; if (claim_id !== 3'd1) begin errors++; $display("FAIL b2b_id2 got %0d exp 1", claim_id); end
      checks++; if (ip !== 6'b000010) begin errors++; $display("FAIL b2b_ip1 got %b exp 000010", ip); end
      tick(); claim = 0;
      checks++; if (ip !== 6'b000000) begin errors++; $display("FAIL b2b_ip2 got %b exp 000000", ip); end
      tick();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL b2b_irq got %b exp 0", irq); end
      checks++; if (claim_id !== 3'd0) begin errors++; $display("FAIL b2b_claim_id got %0d exp 0", claim_id); end
      claim = 1; tick(); claim = 0;
      checks++; if (ip !== 6'b000000 || irq !== 1'b0 || claim_id !== 3'd0)
         begin errors++; $display("FAIL empty_claim got ip=%b irq=%b id=%0d exp 000000/0/0", ip, irq, claim_id); end
   endtask

   task automatic test_tie_threshold();
      set_prio(1, 4); set_prio(2, 4);
      gw_valid = 6'b000110; tick(); gw_valid = '0; tick();
      checks++; if (claim_id !== 3'd1) begin errors++; $display("FAIL tie_id got %0d exp 1", claim_id); end
      thold = 4; tick();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL thold4_irq got %b exp 0", irq); end
      checks++; if (ip !== 6'b000110) begin errors++; $display("FAIL thold4_ip got %b exp 000110", ip); end
      thold = 3; tick();
      checks++; if (irq !== 1'b1 || claim_id !== 3'd1) begin errors++; $display("FAIL thold3 got irq=%b id=%0d exp 1/1", irq, claim_id); end
      ie = 6'b000000; tick();
      checks++; if (irq !== 1'b0 || ip !== 6'b000110) begin errors++; $display("FAIL ie_off got irq=%b ip=%b exp 0/000110", irq, ip); end
      ie = 6'b000110; tick();
   endtask

   task automatic test_complete();
      comp = 1; comp_id = 2; tick(); comp = 0;
      checks++; if (gw_comp !== 6'b000100) begin errors++; $display("FAIL comp2 got %b exp 000100", gw_comp); end
      tick();
      checks++; if (gw_comp !== 6'b000000) begin errors++; $display("FAIL comp2_len got %b exp 000000", gw_comp); end
      comp = 1; comp_id = 0; tick(); comp = 0;
      checks++; if (gw_comp !== 6'b000000) begin errors++; $display("FAIL comp0 got %b exp 000000", gw_comp); end
      ie = 6'b000010; comp = 1; comp_id = 2; tick(); comp = 0; ie = 6'b000110;
      checks++; if (gw_comp !== 6'b000000) begin errors++; $display("FAIL comp_ie_off got %b exp 000000", gw_comp); end
      ie = 6'b111111; comp = 1; comp_id = 6; tick(); comp_id = 7; tick(); comp = 0; ie = 6'b000110;
      checks++; if (gw_comp !== 6'b000000) begin errors++; $display("FAIL comp_range got %b exp 000000", gw_comp); end
      tick();
   endtask

   task automatic test_claim_and_complete();
      logic [N-1:0] exp_comp;
`ifdef PLIC_TARGET_ACTIVE_EN
      exp_comp = 6'b000000;
`else
      exp_comp = 6'b000100;
`endif
      claim = 1; comp = 1; comp_id = 2; tick(); claim = 0; comp = 0;
      checks++; if (ip !== 6'b000100) begin errors++; $display("FAIL simul_ip got %b exp 000100", ip); end
      checks++; if (gw_comp !== exp_comp) begin errors++; $display("FAIL simul_comp got %b exp %b", gw_comp, exp_comp); end
      tick();
      checks++; if (claim_id !== 3'd2) begin errors++; $display("FAIL simul_next_id got %0d exp 2", claim_id); end
   endtask

   task automatic test_reset_mid();
      gw_valid = 6'b000110; tick(); tick();
      checks++; if (irq !== 1'b1 || ip !== 6'b000110) begin errors++; $display("FAIL pre_rst got irq=%b ip=%b exp 1/000110", irq, ip); end
      rst = 1; tick();
      checks++; if (ip !== 6'b000000 || irq !== 1'b0 || claim_id !== 3'd0)
         begin errors++; $display("FAIL mid_rst got ip=%b irq=%b id=%0d exp 000000/0/0", ip, irq, claim_id); end
      checks++; if (gw_ready[2:1] !== 2'b11) begin errors++; $display("FAIL mid_rst_ready got %b exp 11", gw_ready[2:1]); end
      rst = 0; gw_valid = '0; tick();
   endtask

   task automatic test_active();
`ifdef PLIC_TARGET_ACTIVE_EN
      rst = 1; tick(); rst = 0;
      set_prio(1, 3); ie = 6'b000110; thold = 0;
      comp = 1; comp_id = 1; tick(); comp = 0;
      checks++; if (gw_comp !== 6'b000000) begin errors++; $display("FAIL act_early_comp got %b exp 000000", gw_comp); end
      gw_valid = 6'b000010; tick(); gw_valid = '0; tick();
      claim = 1; tick(); claim = 0;
      checks++; if (active !== 6'b000010) begin errors++; $display("FAIL act_claim got %b exp 000010", active); end
      comp = 1; comp_id = 1; tick(); comp = 0;
      checks++; if (gw_comp !== 6'b000010 || active !== 6'b000000)
         begin errors++; $display("FAIL act_comp got comp=%b act=%b exp 000010/000000", gw_comp, active); end
      gw_valid = 6'b000010; tick(); gw_valid = '0; tick();
      claim = 1; comp = 1; comp_id = 1; tick(); claim = 0; comp = 0;
      checks++; if (gw_comp !== 6'b000000 || active !== 6'b000010)
         begin errors++; $display("FAIL act_same_cycle got comp=%b act=%b exp 000000/000010", gw_comp, active); end
`else
      claim = 1; tick(); claim = 0;
      checks++; if (active !== 6'b000000) begin errors++; $display("FAIL act_tied got %b exp 000000", active); end
`endif
   endtask

   initial begin
      rst = 1; gw_valid = '0; prio = '0; ie = '0; thold = '0;
      claim = 0; comp = 0; comp_id = '0;
      test_reset();
      test_pending_select();
      test_back_to_back();
      test_tie_threshold();
      test_complete();
      test_claim_and_complete();
      test_reset_mid();
      test_active();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
